// File: rtl/kpscan.sv
// Keypad column scanner and press/release debouncer for a 4x4 matrix keypad.
// Drives active-low columns, synchronizes rows, and emits one event per physical press.
module kpscan #(
  parameter int unsigned SCAN_DIV     = 50000,
  parameter int unsigned DEBOUNCE_CNT = 20
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [3:0] kpr_raw,
  output logic [3:0] kpr,
  output logic [3:0] kpc,
  input  logic       kphit,
  input  logic [3:0] num,
  output logic       key_valid,
  output logic [3:0] key_code,
  output logic       key_held
);

  localparam int unsigned DIV_W = $clog2(SCAN_DIV);
  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CNT + 1);
  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CNT);
  localparam logic [3:0] NO_KEY   = 4'd11;
  localparam logic [3:0] COL_INIT = 4'b0111;

  typedef enum logic [1:0] {
    S_SCAN,
    S_PRESS_DB,
    S_HELD,
    S_REL_DB
  } state_t;

  logic [3:0]       r_sync1;
  logic [3:0]       r_sync2;
  logic [DIV_W-1:0] r_div;
  logic             w_tick;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [3:0]       r_kpc;
  logic [3:0]       w_kpc_nxt;
  logic [3:0]       r_cand;
  logic [3:0]       w_cand_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [CNT_W-1:0] w_cnt_inc;
  logic             r_key_valid;
  logic             w_key_valid_nxt;
  logic [3:0]       r_key_code;
  logic [3:0]       w_key_code_nxt;
  logic             r_key_held;
  logic             w_key_held_nxt;

  // Two-flop row synchronizer; rows idle high.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1 <= 4'b1111;
      r_sync2 <= 4'b1111;
    end else begin
      r_sync1 <= kpr_raw;
      r_sync2 <= r_sync1;
    end
  end

  // Free-running scan prescaler.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_div <= '0;
    end else if (r_div == DIV_MAX) begin
      r_div <= '0;
    end else begin
      r_div <= r_div + DIV_W'(1);
    end
  end

  assign w_tick    = (r_div == DIV_MAX);
  assign w_cnt_inc = r_cnt + CNT_W'(1);

  // State and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_SCAN;
      r_kpc       <= COL_INIT;
      r_cand      <= NO_KEY;
      r_cnt       <= '0;
      r_key_valid <= 1'b0;
      r_key_code  <= NO_KEY;
      r_key_held  <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_kpc       <= w_kpc_nxt;
      r_cand      <= w_cand_nxt;
      r_cnt       <= w_cnt_nxt;
      r_key_valid <= w_key_valid_nxt;
      r_key_code  <= w_key_code_nxt;
      r_key_held  <= w_key_held_nxt;
    end
  end

  // Next-state logic; every decision is gated by the scan tick.
  always_comb begin
    w_state_nxt     = r_state;
    w_kpc_nxt       = r_kpc;
    w_cand_nxt      = r_cand;
    w_cnt_nxt       = r_cnt;
    w_key_valid_nxt = 1'b0;
    w_key_code_nxt  = r_key_code;
    w_key_held_nxt  = r_key_held;
    if (w_tick) begin
      case (r_state)
        S_SCAN: begin
          if (kphit) begin
            w_cand_nxt  = num;
            w_cnt_nxt   = CNT_W'(1);
            w_state_nxt = S_PRESS_DB;
          end else begin
            w_kpc_nxt = {r_kpc[0], r_kpc[3:1]};
          end
        end
        S_PRESS_DB: begin
          if (kphit && (num == r_cand)) begin
            if (w_cnt_inc == CNT_MAX) begin
              w_cnt_nxt       = CNT_MAX;
              w_key_code_nxt  = r_cand;
              w_key_valid_nxt = 1'b1;
              w_key_held_nxt  = 1'b1;
              w_state_nxt     = S_HELD;
            end else begin
              w_cnt_nxt = w_cnt_inc;
            end
          end else begin
            w_cnt_nxt   = '0;
            w_state_nxt = S_SCAN;
          end
        end
        S_HELD: begin
          // A different key while held is ignored: no rollover.
          if (!kphit) begin
            w_cnt_nxt   = CNT_W'(1);
            w_state_nxt = S_REL_DB;
          end
        end
        S_REL_DB: begin
          if (!kphit) begin
            if (w_cnt_inc == CNT_MAX) begin
              w_cnt_nxt      = '0;
              w_key_held_nxt = 1'b0;
              w_state_nxt    = S_SCAN;
            end else begin
              w_cnt_nxt = w_cnt_inc;
            end
          end else begin
            w_cnt_nxt   = '0;
            w_state_nxt = S_HELD;
          end
        end
        default: begin
          w_state_nxt = S_SCAN;
        end
      endcase
    end
  end

  assign kpr       = r_sync2;
  assign kpc       = r_kpc;
  assign key_valid = r_key_valid;
  assign key_code  = r_key_code;
  assign key_held  = r_key_held;

endmodule

// File: tb/tb_kpscan.sv
// Bench for kpscan: keypad matrix and decoder models plus a key-event scoreboard.
module tb_kpscan;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [3:0]  kpr_raw;
  logic [3:0]  kpr;
  logic [3:0]  kpc;
  logic        kphit;
  logic [3:0]  num;
  logic        key_valid;
  logic [3:0]  key_code;
  logic        key_held;

  logic [15:0] pressed = '0;
  int          n_pos = 0;
  int          n_cmp = 0;
  int          n_bad = 0;
  int          v_cnt = 0;
  logic        prev_v = 1'b0;
  int unsigned exp_q[$];

  always #5 clk = ~clk;

  kpscan #(.SCAN_DIV(4), .DEBOUNCE_CNT(3)) u_dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .kpr_raw   (kpr_raw),
    .kpr       (kpr),
    .kpc       (kpc),
    .kphit     (kphit),
    .num       (num),
    .key_valid (key_valid),
    .key_code  (key_code),
    .key_held  (key_held)
  );

  // Layout: 1 2 3 A / 4 5 6 B / 7 8 9 C / * 0 # D ; row r is kpr bit 3-r, col c is kpc bit 3-c.
  function automatic logic [3:0] keymap(input int idx);
    case (idx)
      0: return 4'd1;   1: return 4'd2;   2: return 4'd3;   3: return 4'd10;
      4: return 4'd4;   5: return 4'd5;   6: return 4'd6;   7: return 4'd12;
      8: return 4'd7;   9: return 4'd8;   10: return 4'd9;  11: return 4'd13;
      12: return 4'd14; 13: return 4'd0;  14: return 4'd15; default: return 4'd12;
    endcase
  endfunction

  always_comb begin
    kpr_raw = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[r*4+c] && !kpc[3-c]) kpr_raw[3-r] = 1'b0;
  end

  always_comb begin
    kphit = ~&kpr;
    num   = 4'd11;
    for (int r = 3; r >= 0; r--)
      for (int c = 0; c < 4; c++)
        if (!kpr[3-r] && !kpc[3-c]) num = keymap(r*4+c);
  end

  // Cycle index aligned with the DUT prescaler: tick cycles are n_pos % 4 == 3.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) n_pos <= 0;
    else          n_pos <= n_pos + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (key_valid) begin
      check("valid_single_cycle", prev_v, 1'b0);
      check("held_with_valid", key_held, 1'b1);
      check("sb_has_entry", exp_q.size() > 0, 1'b1);
      if (exp_q.size() > 0) check("key_code", key_code, exp_q.pop_front());
      v_cnt <= v_cnt + 1;
    end
    prev_v <= key_valid;
  end

  function automatic bit is_tick();
    return (n_pos % 4) == 3;
  endfunction

  function automatic logic [3:0] rot(input int k);
    case (k % 4)
      0: return 4'b0111;
      1: return 4'b1011;
      2: return 4'b1101;
      default: return 4'b1110;
    endcase
  endfunction

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_det(input string tag, output int at);
    at = -1;
    for (int i = 0; i < 100 && at < 0; i++) begin
      @(negedge clk);
      if (is_tick() && kphit) at = n_pos;
    end
    check({tag, "_detect_seen"}, at >= 0, 1'b1);
  endtask

  task automatic wait_valid(input string tag, output int at);
    at = -1;
    for (int i = 0; i < 200 && at < 0; i++) begin
      @(negedge clk);
      if (key_valid) at = n_pos;
    end
    check({tag, "_valid_seen"}, at >= 0, 1'b1);
  endtask

  task automatic wait_fall(input string tag);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (!key_held) done = 1'b1;
    end
    check({tag, "_held_fall"}, done, 1'b1);
  endtask

  // After a release: key_held must still be 1 at the 3rd idle tick and 0 one cycle later.
  task automatic rel_check(input string tag);
    int rt;
    int rn;
    rt = 0;
    rn = -1;
    for (int i = 0; i < 200 && rn < 0; i++) begin
      @(negedge clk);
      if (is_tick() && !kphit) begin
        rt++;
        if (rt == 3) rn = n_pos;
      end
    end
    check({tag, "_rel_ticks_seen"}, rn >= 0, 1'b1);
    check({tag, "_held_at_3rd_tick"}, key_held, 1'b1);
    @(negedge clk);
    check({tag, "_held_after_3rd_tick"}, key_held, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int det;
    int vat;
    int v0;
    int p0;

    // Reset
    cyc(5);
    check("rst_kpc", kpc, 4'b0111);
    check("rst_kpr", kpr, 4'hF);
    check("rst_key_code", key_code, 4'd11);
    check("rst_key_valid", key_valid, 1'b0);
    check("rst_key_held", key_held, 1'b0);
    reset_n = 1'b1;
    for (int i = 0; i < 32; i++) begin
      check("idle_rotate", kpc, rot(n_pos / 4));
      @(negedge clk);
    end

    // Clean press of "5"
    v0 = v_cnt;
    p0 = n_pos;
    exp_q.push_back(5);
    pressed[5] = 1'b1;
    wait_det("p5", det);
    wait_valid("p5", vat);
    check("p5_latency", 32'(vat - det), 32'd9);
    check("p5_kpc_frozen", kpc, 4'b1011);
    while (n_pos < p0 + 40) @(negedge clk);
    pressed[5] = 1'b0;
    rel_check("p5");
    check("p5_kpc_at_fall", kpc, 4'b1011);
    cyc(4);
    check("p5_resume_col", kpc, 4'b1101);
    check("p5_event_count", 32'(v_cnt - v0), 32'd1);

    // Bouncing "9" then stable
    cyc(8);
    v0 = v_cnt;
    for (int i = 0; i < 4 && !is_tick(); i++) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      pressed[10] = ~pressed[10];
      cyc(4);
    end
    check("b9_no_valid_bounce", 32'(v_cnt - v0), 32'd0);
    exp_q.push_back(9);
    pressed[10] = 1'b1;
    wait_valid("b9", vat);
    cyc(8);
    pressed[10] = 1'b0;
    wait_fall("b9");
    check("b9_event_count", 32'(v_cnt - v0), 32'd1);

    // "1" held, then "3" added on the same row
    cyc(8);
    v0 = v_cnt;
    exp_q.push_back(1);
    pressed[0] = 1'b1;
    wait_valid("k1", vat);
    cyc(4);
    pressed[2] = 1'b1;
    cyc(30);
    check("k1_no_rollover", 32'(v_cnt - v0), 32'd1);
    check("k1_code_holds", key_code, 4'd1);
    check("k1_held", key_held, 1'b1);
    pressed[0] = 1'b0;
    pressed[2] = 1'b0;
    wait_fall("k1");

    // Reset during PRESS_DB with "0" held
    cyc(8);
    pressed[13] = 1'b1;
    wait_det("r0", det);
    cyc(2);
    reset_n = 1'b0;
    @(negedge clk);
    check("r0_rst_valid", key_valid, 1'b0);
    check("r0_rst_held", key_held, 1'b0);
    check("r0_rst_kpc", kpc, 4'b0111);
    cyc(4);
    check("r0_rst_valid_late", key_valid, 1'b0);
    reset_n = 1'b1;
    v0 = v_cnt;
    exp_q.push_back(0);
    wait_valid("r0", vat);
    cyc(20);
    check("r0_event_count", 32'(v_cnt - v0), 32'd1);

    // Release glitch on "0": one-tick re-press during REL_DB
    v0 = v_cnt;
    pressed[13] = 1'b0;
    det = -1;
    for (int i = 0; i < 100 && det < 0; i++) begin
      @(negedge clk);
      if (is_tick() && !kphit) det = n_pos;
    end
    check("g_first_rel_tick", det >= 0, 1'b1);
    pressed[13] = 1'b1;
    cyc(4);
    pressed[13] = 1'b0;
    check("g_held_during_glitch", key_held, 1'b1);
    rel_check("g");
    check("g_no_new_valid", 32'(v_cnt - v0), 32'd0);

    cyc(4);
    check("sb_empty", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
